// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I instruction memory slice.
// Holds XLEN, the canonical NOP encoding and the write-handshake states.
package rv32i_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_COMMIT = 2'd1,
      W_ACK    = 2'd2
   } write_state_e;

   // Which source drives the read data output
   typedef enum logic [1:0] {
      RD_ZERO  = 2'd0,
      RD_NOP   = 2'd1,
      RD_ARRAY = 2'd2
   } rd_src_e;

endpackage

// File: rtl/rv32i_imem_array.sv
// Single-port instruction storage: synchronous write, synchronous read.
// Ports: clk, we/wdata (write), re/rdata (read), shared word address addr.
module rv32i_imem_array
   import rv32i_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   rdata
);

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   // rdata only moves on a read, so it holds between fetches
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/rv32i_instruction_memory.sv
// RV32I instruction memory: loader write handshake plus fetch read port.
// Ports: i_clk, i_rst (read path only), instruction_wr_* (loader), rd_* (fetch).
module rv32i_instruction_memory
   import rv32i_pkg::*;
#(
   parameter int              DEPTH_WORDS = 256,
   parameter int              ADDR_W      = $clog2(DEPTH_WORDS),
   parameter logic [XLEN-1:0] NOP_INSTR   = RV32I_NOP
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_instruction_wr_en,
   input  logic [XLEN-1:0] i_instruction_wr_addr,
   input  logic [XLEN-1:0] i_instruction_wr_data,
   output logic            o_instruction_wr_valid,
   output logic            o_instruction_wr_error,
   input  logic            i_rd_en,
   input  logic [XLEN-1:0] i_rd_pc,
   output logic            o_rd_valid,
   output logic [XLEN-1:0] o_rd_data,
   output logic            o_rd_fault,
   output logic            o_rd_stall
);

   // Write side lives outside i_rst so the program can be loaded
   // while fetch is held in reset; it relies on power-up values.
   write_state_e    w_state_q = W_IDLE;
   write_state_e    w_state_d;
   logic [XLEN-1:0] w_addr_q;
   logic [XLEN-1:0] w_addr_d;
   logic [XLEN-1:0] w_data_q;
   logic [XLEN-1:0] w_data_d;
   logic            wr_valid_q = 1'b0;
   logic            wr_valid_d;
   logic            wr_error_q = 1'b0;
   logic            wr_error_d;
   logic            w_oob;

   logic            rd_valid_q;
   logic            rd_fault_q;
   rd_src_e         rd_src_q;
   logic            rd_bad;
   logic            rd_accept;

   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_rdata;

   assign w_oob = (w_addr_q[XLEN-1:ADDR_W] != '0);

   always_ff @(posedge i_clk) begin
      w_state_q  <= w_state_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      wr_valid_q <= wr_valid_d;
      wr_error_q <= wr_error_d;
   end

   always_comb begin
      w_state_d  = w_state_q;
      w_addr_d   = w_addr_q;
      w_data_d   = w_data_q;
      wr_valid_d = 1'b0;
      wr_error_d = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            if (i_instruction_wr_en) begin
               w_addr_d  = i_instruction_wr_addr;
               w_data_d  = i_instruction_wr_data;
               w_state_d = W_COMMIT;
            end
         end
         W_COMMIT: begin
            wr_valid_d = 1'b1;
            wr_error_d = w_oob;
            w_state_d  = W_ACK;
         end
         // wr_en ignored here so a held request is not written twice
         W_ACK:   w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   assign o_instruction_wr_valid = wr_valid_q;
   assign o_instruction_wr_error = wr_error_q;

   // Writes win the single port: a pending or active write stalls fetch
   assign rd_bad = (i_rd_pc[1:0] != 2'b00)
                 | (i_rd_pc[XLEN-1:ADDR_W+2] != '0);

   assign rd_accept = i_rd_en & ~i_rst
                    & (w_state_q == W_IDLE)
                    & ~i_instruction_wr_en;

   assign o_rd_stall = i_rd_en & ~i_rst & ~rd_accept;

   assign mem_we   = (w_state_q == W_COMMIT) & ~w_oob;
   assign mem_re   = rd_accept & ~rd_bad;
   assign mem_addr = (w_state_q == W_COMMIT)
                   ? w_addr_q[ADDR_W-1:0]
                   : i_rd_pc[ADDR_W+1:2];

   rv32i_imem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) u_array (
      .clk   (i_clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (w_data_q),
      .rdata (mem_rdata)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_valid_q <= 1'b0;
         rd_fault_q <= 1'b0;
         rd_src_q   <= RD_ZERO;
      end else begin
         rd_valid_q <= rd_accept;
         rd_fault_q <= rd_accept & rd_bad;
         if (rd_accept) begin
            rd_src_q <= rd_bad ? RD_NOP : RD_ARRAY;
         end
      end
   end

   // Data is selected from registered state, so reset clears it at once
   // and it holds its last value while no new read completes.
   always_comb begin
      o_rd_data = '0;
      unique case (rd_src_q)
         RD_NOP:   o_rd_data = NOP_INSTR;
         RD_ARRAY: o_rd_data = mem_rdata;
         default:  o_rd_data = '0;
      endcase
   end

   assign o_rd_valid = rd_valid_q;
   assign o_rd_fault = rd_fault_q;

endmodule

// File: tb/tb_rv32i_instruction_memory.sv
// Scoreboard bench for rv32i_instruction_memory.
// Reference: plain word array plus byte-address fault rules.
module tb_rv32i_instruction_memory;

   localparam int          DEPTH = 256;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        wr_valid;
   logic        wr_error;
   logic        rd_en = 1'b0;
   logic [31:0] rd_pc = '0;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_fault;
   logic        rd_stall;

   rv32i_instruction_memory dut (
      .i_clk                  (clk),
      .i_rst                  (rst),
      .i_instruction_wr_en    (wr_en),
      .i_instruction_wr_addr  (wr_addr),
      .i_instruction_wr_data  (wr_data),
      .o_instruction_wr_valid (wr_valid),
      .o_instruction_wr_error (wr_error),
      .i_rd_en                (rd_en),
      .i_rd_pc                (rd_pc),
      .o_rd_valid             (rd_valid),
      .o_rd_data              (rd_data),
      .o_rd_fault             (rd_fault),
      .o_rd_stall             (rd_stall)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      logic        fault;
      int          cyc;
   } rexp_t;

   rexp_t       rq[$];
   logic        wq[$];
   logic [31:0] model [DEPTH];
   int          vectors = 0;
   int          miscompares = 0;
   int          wr_pulses = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic rexp_t ref_read(input logic [31:0] pc);
      rexp_t       e;
      int unsigned idx;
      idx   = pc / 4;
      e.cyc = cyc;
      if ((pc % 4) != 0 || idx >= DEPTH) begin
         e.fault = 1'b1;
         e.data  = NOP;
      end else begin
         e.fault = 1'b0;
         e.data  = model[idx];
      end
      return e;
   endfunction

   // Stimulus side: a read issued and not stalled expects a response
   always @(negedge clk) begin
      if (rd_en && !rst && !rd_stall) rq.push_back(ref_read(rd_pc));
   end

   // Monitor side
   always @(negedge clk) begin : mon
      rexp_t e;
      if (wr_valid) begin
         wr_pulses++;
         if (wq.size() == 0) chk("wr_spurious", wr_valid, 0);
         else chk("wr_error", wr_error, wq.pop_front());
      end
      if (rd_valid) begin
         if (rq.size() == 0) chk("rd_spurious", rd_valid, 0);
         else begin
            e = rq.pop_front();
            chk("rd_data", rd_data, e.data);
            chk("rd_fault", rd_fault, e.fault);
            chk("rd_latency", cyc, e.cyc + 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input bit keep_en, output int pulse_cyc);
      int n = 0;
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wq.push_back(a >= DEPTH);
      if (a < DEPTH) model[a] = d;
      do begin
         tick();
         n++;
      end while (!wr_valid && n < 8);
      chk("wr_ack_seen", wr_valid, 1);
      pulse_cyc = cyc;
      tick();
      chk("wr_pulse_width", wr_valid, 0);
      if (!keep_en) wr_en = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] p);
      rd_en = 1'b1;
      rd_pc = p;
      tick();
      rd_en = 1'b0;
      tick();
   endtask

   function automatic logic [31:0] rand_pc();
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r < 3) return 32'($urandom_range(0, 1023)) | 32'h1;
      if (r < 6) return 32'($urandom_range(DEPTH, 4000)) << 2;
      return 32'($urandom_range(0, DEPTH - 1)) << 2;
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pc_cyc;
      int prev;
      int bad_gap;
      int stalls;
      logic [31:0] a;
      logic [31:0] d;

      for (int i = 0; i < DEPTH; i++) model[i] = '0;

      // Reset state, and no read service while held in reset
      rd_en = 1'b1;
      #1;
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_fault", rd_fault, 0);
      chk("rst_rd_stall", rd_stall, 0);
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_wr_error", wr_error, 0);
      tick();
      chk("rst_rd_no_valid", rd_valid, 0);
      rd_en = 1'b0;

      // Load whole memory under reset, wr_en held high throughout
      bad_gap = 0;
      prev    = 0;
      for (int i = 0; i < DEPTH; i++) begin
         do_write(32'(i), 32'(i), i != DEPTH - 1, pc_cyc);
         if (i > 0 && pc_cyc - prev != 3) bad_gap++;
         prev = pc_cyc;
      end
      chk("wr_gap_errors", bad_gap, 0);
      chk("wr_pulse_count", wr_pulses, DEPTH);

      // Back-to-back reads over the full array
      rst = 1'b0;
      tick();
      stalls = 0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_en = 1'b1;
         rd_pc = 32'(i * 4);
         #1;
         if (rd_stall) stalls++;
         tick();
      end
      rd_en = 1'b0;
      tick();
      tick();
      chk("rd_stall_count", stalls, 0);
      chk("rd_hold_valid", rd_valid, 0);
      chk("rd_hold_data", rd_data, model[DEPTH-1]);

      // Out-of-range write, out-of-range read, word 0 intact
      do_write(32'h100, 32'hDEAD_BEEF, 1'b0, pc_cyc);
      do_read(32'h400);
      do_read(32'h0);

      // Misaligned read
      do_read(32'h6);

      // Held read stalled by a write
      a = ($urandom_range(0, 1) == 0) ? 32'd4 : 32'($urandom_range(5, DEPTH - 1));
      d = $urandom;
      rd_en   = 1'b1;
      rd_pc   = 32'h10;
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wq.push_back(1'b0);
      model[a] = d;
      #1;
      chk("stall_wr_req", rd_stall, 1);
      tick();
      wr_en = 1'b0;
      #1;
      chk("stall_commit", rd_stall, 1);
      tick();
      chk("stall_ack", rd_stall, 1);
      tick();
      chk("stall_release", rd_stall, 0);
      tick();
      rd_en = 1'b0;
      tick();

      // Reset pulse during commit
      do_read(32'h20);
      a = 32'($urandom_range(0, DEPTH - 1));
      d = $urandom | 32'h1;
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wq.push_back(1'b0);
      model[a] = d;
      rd_en = 1'b1;
      rd_pc = 32'h24;
      tick();
      wr_en = 1'b0;
      rst   = 1'b1;
      #1;
      chk("rstw_rd_data", rd_data, 0);
      chk("rstw_rd_valid", rd_valid, 0);
      chk("rstw_rd_stall", rd_stall, 0);
      tick();
      chk("rstw_wr_valid", wr_valid, 1);
      rst = 1'b0;
      tick();
      rd_pc = a << 2;
      tick();
      rd_en = 1'b0;
      tick();
      tick();

      // Randomised mix of writes and reads
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 9) < 3) begin
            if ($urandom_range(0, 7) == 0)
               a = 32'($urandom_range(DEPTH, 1000));
            else
               a = 32'($urandom_range(0, DEPTH - 1));
            do_write(a, $urandom, 1'b0, pc_cyc);
         end else begin
            rd_en = 1'b1;
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
               rd_pc = rand_pc();
               tick();
            end
            rd_en = 1'b0;
            tick();
         end
      end

      tick();
      tick();
      tick();
      chk("rd_queue_drained", rq.size(), 0);
      chk("wr_queue_drained", wq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
